// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between control and the HI/LO multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  modport master (output i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
                  input  o_busy, o_done, o_hi, o_lo);
  modport slave  (input  i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
                  output o_busy, o_done, o_hi, o_lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide (mult, multu, div, divu).
// MDU_FAST_MUL_EN: mult/multu become single-cycle array multiplies; divides stay iterative.
module mul_div_unit #(parameter int WIDTH = 32) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_op;
  logic               r_sa, r_sb, r_done;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_x, r_m, r_hi, r_lo;
  logic               w_sa, w_sb, w_fast, w_neg;
  logic [WIDTH-1:0]   w_ma, w_mb, w_q, w_r;
  logic [WIDTH:0]     w_madd, w_t;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod, w_pfix;
  assign w_sa = ~bus.i_op[0] & bus.i_a[WIDTH-1];
  assign w_sb = ~bus.i_op[0] & bus.i_b[WIDTH-1];
  assign w_ma = w_sa ? -bus.i_a : bus.i_a;
  assign w_mb = w_sb ? -bus.i_b : bus.i_b;
`ifdef MDU_FAST_MUL_EN
  logic        [2*WIDTH-1:0] w_uprod, w_fprod;
  logic signed [2*WIDTH-1:0] w_sprod;
  assign w_uprod = bus.i_a * bus.i_b;
  assign w_sprod = $signed(bus.i_a) * $signed(bus.i_b);
  assign w_fprod = bus.i_op[0] ? w_uprod : w_sprod;
  assign w_fast  = ~bus.i_op[1];
`else
  assign w_fast  = 1'b0;
`endif
  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign w_madd = r_acc + (r_x[0] ? {1'b0, r_m} : '0);
  // Divide: shift the next dividend bit into the remainder and subtract when it fits.
  assign w_t    = {r_acc[WIDTH-1:0], r_x[WIDTH-1]};
  assign w_diff = {1'b0, w_t} - {2'b0, r_m};
  assign w_ge   = ~w_diff[WIDTH+1];
  assign w_neg  = r_sa ^ r_sb;
  assign w_prod = {r_acc[WIDTH-1:0], r_x};
  assign w_pfix = w_neg ? -w_prod : w_prod;
  assign w_q    = w_neg ? -r_x : r_x;
  assign w_r    = r_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? ((bus.i_start && !w_fast) ? S_RUN : S_IDLE) :
             r_state == S_RUN  ? (r_count == CW'(WIDTH-1) ? S_FIX : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_acc   <= '0;
      r_x     <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE:
          if (bus.i_start) begin
`ifdef MDU_FAST_MUL_EN
            if (w_fast) begin
              {r_hi, r_lo} <= w_fprod;
              r_done       <= 1'b1;
            end else
`endif
            begin
              r_op    <= bus.i_op;
              r_sa    <= w_sa;
              r_sb    <= w_sb;
              r_acc   <= '0;
              r_x     <= bus.i_op[1] ? w_ma : w_mb;
              r_m     <= bus.i_op[1] ? w_mb : w_ma;
              r_count <= '0;
            end
          end else begin
            if (bus.i_hi_we) r_hi <= bus.i_wdata;
            if (bus.i_lo_we) r_lo <= bus.i_wdata;
          end
        S_RUN: begin
          r_count <= r_count + CW'(1);
          r_acc   <= r_op[1] ? (w_ge ? w_diff[WIDTH:0] : w_t) : {1'b0, w_madd[WIDTH:1]};
          r_x     <= r_op[1] ? {r_x[WIDTH-2:0], w_ge} : {w_madd[0], r_x[WIDTH-1:1]};
        end
        S_FIX: begin
          {r_hi, r_lo} <= r_op[1] ? {w_r, w_q} : w_pfix;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  assign bus.o_busy = r_state != S_IDLE;
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for the HI/LO multiply/divide unit.
module tb_mul_div_unit;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  mul_div_unit_if #(.WIDTH(32)) bus();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = 0;
    while (!bus.o_done && edges < 100) begin
      if (bus.o_busy) busy_cyc++;
      @(negedge clk);
      edges++;
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e,
                        input int lat);
    int edges, busy_cyc;
    start_op(op, a, b);
    wait_done(edges, busy_cyc);
    check({tag, " latency"}, edges, lat);
    check({tag, " busy cycles"}, busy_cyc, lat);
    check({tag, " busy at done"}, bus.o_busy, 0);
    check({tag, " hi"}, bus.o_hi, hi_e);
    check({tag, " lo"}, bus.o_lo, lo_e);
    @(negedge clk);
    check({tag, " done pulse"}, bus.o_done, 0);
  endtask
  initial begin
    int edges, busy_cyc, n_done;
    bus.i_start = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_hi_we = 1'b0;
    bus.i_lo_we = 1'b0;
    bus.i_wdata = '0;
    rst = 1'b1;
    #2;
    check("reset busy", bus.o_busy, 0);
    check("reset done", bus.o_done, 0);
    check("reset hi", bus.o_hi, 0);
    check("reset lo", bus.o_lo, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.i_hi_we = 1'b1;
    bus.i_wdata = 32'h0000_1234;
    @(negedge clk);
    bus.i_hi_we = 1'b0;
    check("mthi hi", bus.o_hi, 32'h0000_1234);
    check("mthi lo", bus.o_lo, 0);
    bus.i_hi_we = 1'b1;
    bus.i_lo_we = 1'b1;
    bus.i_wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.i_hi_we = 1'b0;
    bus.i_lo_we = 1'b0;
    check("mthi+mtlo hi", bus.o_hi, 32'h0000_ABCD);
    check("mthi+mtlo lo", bus.o_lo, 32'h0000_ABCD);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = DIVU;
    bus.i_a     = 32'd6;
    bus.i_b     = 32'd3;
    bus.i_hi_we = 1'b1;
    bus.i_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_hi_we = 1'b0;
    check("start beats mthi hi", bus.o_hi, 32'h0000_ABCD);
    wait_done(edges, busy_cyc);
    check("divu 6/3 latency", edges, 33);
    check("divu 6/3 hi", bus.o_hi, 0);
    check("divu 6/3 lo", bus.o_lo, 2);
    run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("mult -3*7", MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_op("div 9/0", DIV, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 33);
    run_op("div -8/0", DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'h0000_0001, 33);
    run_op("mult 3*4", MULT, 32'd3, 32'd4, 32'h0, 32'h0000_000C, MUL_LAT);
    start_op(DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = MULTU;
    bus.i_a     = 32'd5;
    bus.i_b     = 32'd6;
    bus.i_lo_we = 1'b1;
    bus.i_wdata = 32'h5555_5555;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_lo_we = 1'b0;
    check("mtlo while busy lo", bus.o_lo, 32'h0000_000C);
    check("busy at E5", bus.o_busy, 1);
    wait_done(edges, busy_cyc);
    check("restart ignored latency", edges, 28);
    check("restart ignored hi", bus.o_hi, 32'd2);
    check("restart ignored lo", bus.o_lo, 32'd14);
    start_op(DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", bus.o_busy, 0);
    check("abort hi", bus.o_hi, 0);
    check("abort lo", bus.o_lo, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) n_done++;
    end
    check("abort no done", n_done, 0);
    check("abort idle busy", bus.o_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
